// File: rtl/truth_table_reader.sv
// truth_table_reader: drives minterms 00..11 into a 2-input gate, captures its truth table and grades it.
// Optional TRUTH_TABLE_READER_DUAL_EN adds a second captured table and an equivalence check.
module truth_table_reader #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       x,
    output logic       y,
    input  logic       s,
`ifdef TRUTH_TABLE_READER_DUAL_EN
    input  logic       s_b,
    output logic [3:0] table_b,
    output logic [3:0] diff_mask,
    output logic       equiv,
`endif
    output logic       busy,
    output logic       done,
    output logic [3:0] table_o,
    output logic       match,
    output logic [3:0] mismatch_mask
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;
    state_t     state_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic [3:0] table_q;
    logic [3:0] exp_q;
    logic       x_q, y_q, busy_q, done_q, valid_q;
`ifdef TRUTH_TABLE_READER_DUAL_EN
    logic [3:0] table_b_q;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            table_q   <= '0;
            exp_q     <= '0;
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef TRUTH_TABLE_READER_DUAL_EN
            table_b_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    exp_q     <= expected;
                    idx_q     <= '0;
                    table_q   <= '0;
`ifdef TRUTH_TABLE_READER_DUAL_EN
                    table_b_q <= '0;
`endif
                    busy_q    <= 1'b1;
                    valid_q   <= 1'b0;
                    state_q   <= APPLY;
                end
                APPLY: begin
                    x_q     <= idx_q[1];
                    y_q     <= idx_q[0];
                    cnt_q   <= 4'(SETTLE);
                    state_q <= (SETTLE == 0) ? SAMPLE : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= SAMPLE;
                end
                SAMPLE: begin
                    table_q[idx_q]   <= s;
`ifdef TRUTH_TABLE_READER_DUAL_EN
                    table_b_q[idx_q] <= s_b;
`endif
                    // done and busy are registered here so they change on the edge entering DONE
                    if (idx_q == 2'd3) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= APPLY;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign x       = x_q;
    assign y       = y_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign table_o = table_q;
    // valid_q keeps the grade at 0 after reset, where table and expected are both 0
    assign match         = valid_q && (table_q == exp_q);
    assign mismatch_mask = valid_q ? (table_q ^ exp_q) : 4'b0;
`ifdef TRUTH_TABLE_READER_DUAL_EN
    assign table_b   = table_b_q;
    assign diff_mask = valid_q ? (table_q ^ table_b_q) : 4'b0;
    assign equiv     = valid_q && (table_q == table_b_q);
`endif
endmodule

// File: doc/truth_table_reader.md
# truth_table_reader

Sequential response reader for 2-input combinational gate modules. On `start` it drives the four input minterms (00, 01, 10, 11) into a device under test and samples the DUT output after a programmable settle time. It assembles the captured 4-bit truth table and compares it against an expected table. It is the receiving end of the gate exercises: those modules produce `s` from `(a, b)`, and this block reads `s` back and grades it, replacing hand-read `$monitor` output.

## Interface

Parameters:
- `SETTLE`, default 1: idle cycles between applying a minterm and sampling `s`. Legal range is 0..15.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a read; accepted only in IDLE.
- `expected`, input, 4: expected truth table; bit i is the output for minterm i. Latched when `start` is accepted.
- `x`, output, 1: DUT input a; equals minterm index bit 1.
- `y`, output, 1: DUT input b; equals minterm index bit 0.
- `s`, input, 1: DUT output.
- `busy`, output, 1: high from start acceptance until `done`.
- `done`, output, 1: one-cycle pulse when the table is complete.
- `table`, output, 4: captured truth table; held until the next accepted `start`.
- `match`, output, 1: `table == expected_latched`; valid from `done` until the next `start`.
- `mismatch_mask`, output, 4: `table ^ expected_latched`; same validity as `match`.

## Operation

- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- **IDLE**
  - `start` = 1: latch `expected`, set index to 0, clear `table`, go to APPLY.
  - Otherwise: hold.
- **APPLY**
  - Register `x = idx[1]`, `y = idx[0]`.
  - Load settle counter with `SETTLE`.
  - Go to WAIT, or directly to SAMPLE if `SETTLE` = 0.
- **WAIT**
  - Decrement the settle counter.
  - When it reaches 0, go to SAMPLE.
- **SAMPLE**
  - Set `table[idx] <= s`.
  - If idx = 3, go to DONE; otherwise increment idx and go to APPLY.
- **DONE**
  - Pulse `done`, drop `busy`, go to IDLE.
  - `match` and `mismatch_mask` are combinational from `table` and the latched expected table. They are gated to 0 while `busy`.
- Index is 2 bits and counts 0..3 only; no wrap-around occurs during a run.
- `start` while not in IDLE is ignored. It is not queued.
- `start` asserted in the same cycle as DONE is ignored; it is accepted the following cycle, in IDLE.
- `reset` mid-run aborts the run and returns all registers to reset values on that edge. `reset` has priority over `start`.
- Reset values: `x` = 0, `y` = 0, `busy` = 0, `done` = 0, `table` = 0, latched expected = 0, `match` = 0, `mismatch_mask` = 0, state = IDLE.

## Timing

- Per minterm: APPLY takes 1 cycle, WAIT takes `SETTLE` cycles, SAMPLE takes 1 cycle.
- Latency: with start accepted at edge 0, `done` is high during cycle 4·(SETTLE+2)+1. This is cycle 13 for SETTLE = 1 and cycle 9 for SETTLE = 0.
- `busy` rises the cycle after start acceptance and falls together with the `done` pulse.
- `x`/`y` change only at APPLY edges and hold stable through WAIT and SAMPLE.
- After the run, `x` and `y` stay at 1, 1 until reset or the next start.
- `s` is sampled at the SAMPLE edge, so the DUT path from `x`/`y` to `s` must settle within `SETTLE`+1 cycles.

## Configuration

- Macro: `TRUTH_TABLE_READER_DUAL_EN`.
- Defined:
  - Adds input `s_b` (1 bit): the output of a second implementation of the same function, for example the gate form versus the expression form.
  - `s_b` is sampled alongside `s` into `table_b` (4-bit output, reset 0).
  - Adds `diff_mask = table ^ table_b` (4-bit output) and `equiv = (diff_mask == 0)` (1-bit output).
  - `diff_mask` and `equiv` follow the same validity and gating as `match`.
- Undefined: none of these ports or registers exist; the block behaves exactly as described above.

## Test plan

- DUT `s = x | ~y`, `expected` = 4'b1101, SETTLE = 1, pulse `start` → `done` at cycle 13, `table` = 4'b1101, `match` = 1, `mismatch_mask` = 0.
- Same DUT, `expected` = 4'b0010 → `table` = 4'b1101, `match` = 0, `mismatch_mask` = 4'b1111.
- Assert `reset` in cycle 6 of a run → next cycle `busy` = 0, `table` = 0, `x` = `y` = 0, no `done`. A new `start` then completes normally.
- Pulse `start` again at cycles 3 and 12 of a run → ignored. A single `done` fires at cycle 13; a `start` at cycle 14 begins a new run.
- SETTLE = 0, DUT `s = x & y`, `expected` = 4'b1000 → `done` at cycle 9, `match` = 1.
- With `TRUTH_TABLE_READER_DUAL_EN`: `s = x | ~y`, `s_b = x & ~y` → `table` = 4'b1101, `table_b` = 4'b0100, `diff_mask` = 4'b1001, `equiv` = 0.
